// File: rtl/red_sched.sv
// red_sched: shares a single red reduction unit between two requesters.
//
// red(A, B) adds the four bytes of the operand pair and zero-extends the result to 16 bits:
//   red = A[15:8] + A[7:0] + B[15:8] + B[7:0]
//
// Operation: IDLE accepts one operand pair and captures it. EXEC registers the reduction
// result. RESP holds the result until the consumer takes it.
//
// Build option:
//   RED_SCHED_RR_EN  When defined, contention is resolved round-robin using a last-grant
//                    pointer. When undefined, requester 0 has fixed priority and no pointer
//                    register exists.
module red_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_sum,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q;
  logic [15:0] cap_a_q;
  logic [15:0] cap_b_q;
  logic        cap_id_q;
  logic        resp_valid_q;
  logic        resp_id_q;
  logic [15:0] resp_sum_q;

  logic        gnt0;
  logic        gnt1;
  logic        accept;
  logic [15:0] red_sum;

`ifdef RED_SCHED_RR_EN
  // A reset value of 1 means the first contention after reset is granted to requester 0.
  logic last_q;

  // Last-grant pointer. It is updated on every accept, including uncontended ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= gnt1;
    end
  end
`endif

  // The shared reduction unit. It is fed only from the capture registers.
  always_comb begin
    red_sum = {8'h00, cap_a_q[15:8]} + {8'h00, cap_a_q[7:0]} +
              {8'h00, cap_b_q[15:8]} + {8'h00, cap_b_q[7:0]};
  end

  // Grants are issued only in IDLE and only outside reset. At most one grant is high.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle && !rst) begin
      if (req0_valid && req1_valid) begin
`ifdef RED_SCHED_RR_EN
        gnt0 = last_q;
        gnt1 = !last_q;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign accept     = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Main FSM. It also captures the operands and holds the registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cap_a_q      <= 16'h0000;
      cap_b_q      <= 16'h0000;
      cap_id_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_sum_q   <= 16'h0000;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            cap_a_q  <= gnt1 ? req1_a : req0_a;
            cap_b_q  <= gnt1 ? req1_b : req0_b;
            cap_id_q <= gnt1;
            state_q  <= StExec;
          end
        end
        StExec: begin
          resp_sum_q   <= red_sum;
          resp_id_q    <= cap_id_q;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            // Clear the sum so it reads zero whenever no response is offered.
            resp_valid_q <= 1'b0;
            resp_sum_q   <= 16'h0000;
            state_q      <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign busy       = (state_q != StIdle);

endmodule
